// File: rtl/mlp_io_pkg.sv
// Shared types and default sizes for the printed-MLP feature loader.
// Defaults match the Pendigits network: 16 features x 4 bit, 4-bit class.
package mlp_io_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        HOLD
    } loader_state_t;

    localparam int DEF_NUM_A    = 16;
    localparam int DEF_WIDTH_A  = 4;
    localparam int DEF_OUTWIDTH = 4;

endpackage

// File: rtl/mlp_settle_timer.sv
// Down-counter timing the propagation window of the combinational MLP.
// Load presets SETTLE_CYC-1; zero flags the final settle cycle.
module mlp_settle_timer #(
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] INIT = CW'(SETTLE_CYC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= INIT;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mlp_feature_loader.sv
// Serial-to-parallel front-end for the combinational printed MLP:
// gathers features, holds them while the net settles, returns the class.
module mlp_feature_loader
    import mlp_io_pkg::*;
#(
    parameter int NUM_A      = DEF_NUM_A,
    parameter int WIDTH_A    = DEF_WIDTH_A,
    parameter int OUTWIDTH   = DEF_OUTWIDTH,
    parameter int SETTLE_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH_A-1:0]         s_data,
    input  logic                       s_last,
    output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
    input  logic [OUTWIDTH-1:0]        mlp_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUTWIDTH-1:0]        m_class,
    output logic                       frame_err
);

    localparam int IW = $clog2(NUM_A);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_A - 1);

    loader_state_t state;
    logic [IW-1:0] idx;
    logic          accept;
    logic          is_end;
    logic          good_end;
    logic          settle_zero;

    // Ready is a pure state decode; m_ready never reaches it.
    assign s_ready  = (state == LOAD) && !rst;
    assign accept   = s_valid && s_ready;
    assign is_end   = (idx == LAST_IDX);
    assign good_end = accept && is_end && s_last;

    mlp_settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(good_end),
        .dec (state == SETTLE),
        .zero(settle_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            mlp_inp   <= '0;
            m_class   <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Misplaced or missing s_last: drop the sample, restart at slot 0.
            frame_err <= accept && (s_last != is_end);
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        for (int k = 0; k < NUM_A; k++) begin
                            if (idx == IW'(k)) begin
                                mlp_inp[k*WIDTH_A +: WIDTH_A] <= s_data;
                            end
                        end
                        if (s_last || is_end) begin
                            idx <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                        if (good_end) begin
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_zero) begin
                        m_class <= mlp_out;
                        m_valid <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_feature_loader.sv
// Scoreboard bench for mlp_feature_loader with a stand-in MLP whose
// output is only correct during the final settle cycle.
module tb_mlp_feature_loader;

    localparam int NA = 16;
    localparam int W  = 4;
    localparam int OW = 4;
    localparam int S  = 4;

    typedef struct {
        logic [OW-1:0]   c;
        logic [NA*W-1:0] v;
        int              rise;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid;
    logic            s_ready;
    logic [W-1:0]    s_data;
    logic            s_last;
    logic [NA*W-1:0] mlp_inp;
    logic [OW-1:0]   mlp_out;
    logic            m_valid;
    logic            m_ready;
    logic [OW-1:0]   m_class;
    logic            frame_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int good_cyc = -1;
    int idx_m  = 0;
    logic [W-1:0] slots [NA];
    exp_t q [$];
    int   fe_q [$];
    logic [OW-1:0] hold_cls;
    logic pmv = 1'b0;
    bit   rnd_ready = 1'b0;

    mlp_feature_loader #(
        .NUM_A(NA), .WIDTH_A(W), .OUTWIDTH(OW), .SETTLE_CYC(S)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last),
        .mlp_inp(mlp_inp), .mlp_out(mlp_out),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_class(m_class), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Stand-in classifier: weighted nibble sum mod 16.
    function automatic logic [OW-1:0] cls(input logic [NA*W-1:0] v);
        int s = 0;
        for (int k = 0; k < NA; k++) s += (2 * k + 1) * int'(v[k*W +: W]);
        return OW'(s);
    endfunction

    function automatic logic [NA*W-1:0] pack_slots();
        logic [NA*W-1:0] v;
        for (int k = 0; k < NA; k++) v[k*W +: W] = slots[k];
        return v;
    endfunction

    // Output is garbled except in the one cycle the loader should sample it.
    always_comb begin
        mlp_out = cls(mlp_inp) ^ ((cyc == good_cyc) ? 4'h0 : 4'hA);
    end

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cyc %0d)", nm, cyc);
    endtask

    task automatic model_reset();
        idx_m = 0;
        for (int k = 0; k < NA; k++) slots[k] = '0;
        q.delete();
        fe_q.delete();
        good_cyc = -1;
    endtask

    // Reference framing rules applied to a beat accepted at cycle n.
    task automatic model_beat(input logic [W-1:0] d, input logic l,
                              input int n);
        exp_t e;
        bit at_end;
        slots[idx_m] = d;
        at_end = (idx_m == NA - 1);
        if (l && at_end) begin
            e.v = pack_slots();
            e.c = cls(e.v);
            e.rise = n + S + 1;
            q.push_back(e);
            good_cyc = n + S;
            idx_m = 0;
        end else if (l || at_end) begin
            fe_q.push_back(n + 1);
            idx_m = 0;
        end else begin
            idx_m++;
        end
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l,
                             input int gap);
        bit acc = 1'b0;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int w = 0; w < 300 && !acc; w++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (acc) model_beat(d, l, cyc);
        else bound_fail("beat_accept");
    endtask

    task automatic send_sample(input int nb, input int lastpos,
                               input int maxgap, input bit ramp);
        logic [W-1:0] d;
        for (int b = 0; b < nb; b++) begin
            d = ramp ? W'(b) : W'($urandom_range(0, 15));
            send_beat(d, b == lastpos, $urandom_range(0, maxgap));
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            idle = (q.size() == 0) && !m_valid;
            if (!idle) begin
                @(posedge clk);
                #1;
            end
        end
        if (!idle) bound_fail("idle");
    endtask

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard whenever the DUT raises a result.
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            pmv = 1'b0;
        end else begin
            if (frame_err) begin
                if (fe_q.size() == 0) chk("unexp_frame_err", frame_err, 0);
                else chk("frame_err_cyc", cyc, fe_q.pop_front());
            end
            if (m_valid && !pmv) begin
                if (q.size() == 0) begin
                    chk("unexp_m_valid", m_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("class", m_class, e.c);
                    chk("vector", mlp_inp, e.v);
                    chk("latency", cyc, e.rise);
                end
                hold_cls = m_class;
            end else if (m_valid) begin
                chk("hold_class", m_class, hold_cls);
            end
            if (m_valid) chk("s_ready_in_hold", s_ready, 0);
            pmv = m_valid;
        end
    end

    initial begin
        logic [63:0] ramp_vec;
        bit seen;
        int r;
        int p;
        ramp_vec = 64'hFEDCBA9876543210;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inp", mlp_inp, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_class", m_class, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Ramp sample: features k, last on beat 15.
        send_sample(16, 15, 0, 1);
        chk("ramp_vec", mlp_inp, ramp_vec);
        wait_idle();

        // Early s_last, then a clean sample.
        send_sample(10, 9, 0, 0);
        send_sample(16, 15, 1, 0);
        wait_idle();

        // Missing s_last on beat 15.
        send_sample(16, -1, 0, 0);
        repeat (S + 4) @(posedge clk);
        #1;
        wait_idle();

        // Consumer stalls for 20 cycles in HOLD while a beat is offered.
        m_ready = 1'b0;
        send_sample(16, 15, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = m_valid;
        end
        if (!seen) bound_fail("hold_m_valid");
        s_valid = 1'b1;
        s_data  = 4'h5;
        repeat (20) begin
            @(negedge clk);
            chk("stall_m_valid", m_valid, 1);
            chk("stall_s_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("release_m_valid", m_valid, 0);
        chk("release_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        // Reset while beat 7 is offered.
        send_sample(7, -1, 0, 0);
        s_valid = 1'b1;
        s_data  = 4'h7;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rstload_s_ready", s_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rstload_inp", mlp_inp, 0);
        chk("rstload_m_valid", m_valid, 0);
        chk("rstload_frame_err", frame_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_valid = 1'b0;

        // Reset during SETTLE discards the pending result.
        send_sample(16, 15, 0, 0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rstset_inp", mlp_inp, 0);
        chk("rstset_m_valid", m_valid, 0);
        chk("rstset_m_class", m_class, 0);
        chk("rstset_frame_err", frame_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (S + 4) @(posedge clk);
        #1;
        send_sample(16, 15, 0, 0);
        wait_idle();

        // Random traffic: gaps 0-3, random back-pressure, some bad frames.
        rnd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                p = $urandom_range(0, 14);
                send_sample(p + 1, p, 3, 0);
            end else if (r == 1) begin
                send_sample(16, -1, 3, 0);
            end else begin
                send_sample(16, 15, 3, 0);
            end
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("results_pending", q.size(), 0);
        chk("frame_err_pending", fe_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
